// File: rtl/reg_access_pkg.sv
// Shared types for the register access sequencer: FSM states and the queued command format.
package reg_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [2:0] addr;
    logic [1:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/reg_access_fifo.sv
// Synchronous command FIFO with extra-MSB pointers; head entry is visible combinationally.
module reg_access_fifo
  import reg_access_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [CMD_W-1:0] push_cmd,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CMD_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        push_ok;
  logic        pop_ok;

  // Full when the wrap bits differ but the slot indices coincide.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= cmd_t'(push_cmd);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/reg_access_seq.sv
// Queues host register commands and replays them as single-cycle WRITE/READ strobes,
// returning read data through a ready/valid response port.
module reg_access_seq
  import reg_access_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WR,
  input  logic [2:0] CMD_ADDR,
  input  logic [1:0] CMD_DATA,
  output logic       WRITE,
  output logic       READ,
  output logic [2:0] ADDR,
  output logic [1:0] WRITE_DATA,
  input  logic [1:0] READ_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [2:0] RSP_ADDR,
  output logic [1:0] RSP_DATA
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t     state_reg, state_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       op_wr_reg;
  logic [2:0] addr_reg;
  logic [1:0] wdata_reg;
  logic [2:0] rsp_addr_reg;
  logic [1:0] rsp_data_reg;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       capture;
  cmd_t       cmd_in;
  cmd_t       head_cmd;
  logic [CMD_W-1:0] head_bits;

  assign cmd_in   = '{wr: CMD_WR, addr: CMD_ADDR, data: CMD_DATA};
  assign head_cmd = cmd_t'(head_bits);

  reg_access_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .push     (CMD_VALID),
    .push_cmd (cmd_in),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_bits)
  );

  assign CMD_READY  = !fifo_full;
  assign ADDR       = addr_reg;
  assign WRITE_DATA = wdata_reg;
  assign RSP_VALID  = (state_reg == RESP);
  assign RSP_ADDR   = rsp_addr_reg;
  assign RSP_DATA   = rsp_data_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fifo_pop   = 1'b0;
    capture    = 1'b0;
    WRITE      = 1'b0;
    READ       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        WRITE      = op_wr_reg;
        READ       = !op_wr_reg;
        cnt_next   = 2'd0;
        state_next = op_wr_reg ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        // The final wait cycle is exactly RD_LAT cycles after the READ strobe.
        if (cnt_reg == LAT_LAST) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      RESP: begin
        if (RSP_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      op_wr_reg    <= 1'b0;
      addr_reg     <= 3'd0;
      wdata_reg    <= 2'd0;
      rsp_addr_reg <= 3'd0;
      rsp_data_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (fifo_pop) begin
        op_wr_reg <= head_cmd.wr;
        addr_reg  <= head_cmd.addr;
        wdata_reg <= head_cmd.data;
      end
      if (capture) begin
        rsp_addr_reg <= addr_reg;
        rsp_data_reg <= READ_DATA;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Directed and random checks of reg_access_seq against a register-file model and scoreboards.
module tb_reg_access_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_WR = 1'b0;
  logic [2:0] CMD_ADDR = 3'd0;
  logic [1:0] CMD_DATA = 2'd0;
  logic       RSP_READY = 1'b1;
  logic       CMD_READY, WRITE, READ, RSP_VALID;
  logic [2:0] ADDR, RSP_ADDR;
  logic [1:0] WRITE_DATA, RSP_DATA, READ_DATA;

  logic       c3_valid = 1'b0;
  logic       c3_wr = 1'b0;
  logic [2:0] c3_addr = 3'd0;
  logic [1:0] c3_data = 2'd0;
  logic       c3_rsp_ready = 1'b1;
  logic       c3_ready, c3_write, c3_read, c3_rsp_valid;
  logic [2:0] c3_addr_out, c3_rsp_addr;
  logic [1:0] c3_wdata, c3_rsp_data;
  logic [1:0] rd3_cnt = 2'd0;

  always #5 CLK = ~CLK;

  reg_access_seq #(.FIFO_DEPTH(4), .RD_LAT(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_WR(CMD_WR), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
    .WRITE(WRITE), .READ(READ), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_ADDR(RSP_ADDR), .RSP_DATA(RSP_DATA)
  );

  reg_access_seq #(.FIFO_DEPTH(4), .RD_LAT(3)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(c3_valid), .CMD_READY(c3_ready),
    .CMD_WR(c3_wr), .CMD_ADDR(c3_addr), .CMD_DATA(c3_data),
    .WRITE(c3_write), .READ(c3_read), .ADDR(c3_addr_out), .WRITE_DATA(c3_wdata),
    .READ_DATA(rd3_cnt), .RSP_VALID(c3_rsp_valid), .RSP_READY(c3_rsp_ready),
    .RSP_ADDR(c3_rsp_addr), .RSP_DATA(c3_rsp_data)
  );

  // Register block seen by the RD_LAT=1 instance; the RD_LAT=3 one reads a free-running count.
  logic [1:0] regs [8] = '{default: 2'b00};
  logic [1:0] rd_pipe = 2'b00;
  assign READ_DATA = rd_pipe;
  always @(posedge CLK) begin
    if (WRITE) regs[ADDR] <= WRITE_DATA;
    if (READ)  rd_pipe <= regs[ADDR];
    rd3_cnt <= rd3_cnt + 2'd1;
  end

  int         checks = 0;
  int         errors = 0;
  int         wr_seen = 0;
  int         rd_seen = 0;
  bit         rnd_mode = 1'b0;
  logic [1:0] mdl [8] = '{default: 2'b00};
  logic [4:0] wq [$];
  logic [4:0] rq [$];
  logic [4:0] mon_e;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (WRITE || READ) chk("strobe_exclusive", {7'd0, WRITE && READ}, 8'd0);
      if (WRITE) begin
        wr_seen++;
        if (wq.size() == 0) chk("unexpected_write", {3'd0, ADDR, WRITE_DATA}, 8'hff);
        else begin
          mon_e = wq.pop_front();
          chk("write_addr_data", {3'd0, ADDR, WRITE_DATA}, {3'd0, mon_e});
        end
      end
      if (READ) rd_seen++;
      if (RSP_VALID && RSP_READY) begin
        if (rq.size() == 0) chk("unexpected_rsp", {3'd0, RSP_ADDR, RSP_DATA}, 8'hff);
        else begin
          mon_e = rq.pop_front();
          chk("rsp_addr_data", {3'd0, RSP_ADDR, RSP_DATA}, {3'd0, mon_e});
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic wr, input logic [2:0] a, input logic [1:0] d);
    int n;
    CMD_VALID = 1'b1; CMD_WR = wr; CMD_ADDR = a; CMD_DATA = d;
    n = 0;
    forever begin
      @(negedge CLK);
      if (CMD_READY || n >= 200) break;
      n++;
      @(posedge CLK); #1;
      if (rnd_mode) RSP_READY = 1'b1;
    end
    if (!CMD_READY) begin
      chk("accept_timeout", {7'd0, CMD_READY}, 8'd1);
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      return;
    end
    if (wr) begin
      mdl[a] = d;
      wq.push_back({a, d});
    end else begin
      rq.push_back({a, mdl[a]});
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    if (rnd_mode) RSP_READY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    RSP_READY = 1'b1;
    while ((wq.size() != 0 || rq.size() != 0) && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drain_pending", 8'(wq.size() + rq.size()), 8'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, {7'd0, CMD_READY}, 8'd1);
    chk({tag, "_write"}, {7'd0, WRITE}, 8'd0);
    chk({tag, "_read"}, {7'd0, READ}, 8'd0);
    chk({tag, "_addr"}, {5'd0, ADDR}, 8'd0);
    chk({tag, "_wdata"}, {6'd0, WRITE_DATA}, 8'd0);
    chk({tag, "_rsp_valid"}, {7'd0, RSP_VALID}, 8'd0);
    chk({tag, "_rsp_addr"}, {5'd0, RSP_ADDR}, 8'd0);
    chk({tag, "_rsp_data"}, {6'd0, RSP_DATA}, 8'd0);
  endtask

  initial begin
    int n, k, base_rd, base_wr;
    logic [1:0] exp3;
    logic       rwr;
    logic [2:0] ra;
    logic [1:0] rdat;

    // Power-up reset, then release; the first cycle must carry no strobe.
    #1 RST_N = 1'b0;
    #3 chk_reset_outputs("reset");
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);
    chk("release_write", {7'd0, WRITE}, 8'd0);
    chk("release_read", {7'd0, READ}, 8'd0);
    @(posedge CLK); #1;

    // Single write: strobe exactly two cycles after acceptance.
    send(1'b1, 3'd0, 2'b10);
    @(negedge CLK); chk("w1_cycle1_write", {7'd0, WRITE}, 8'd0);
    @(negedge CLK); chk("w1_cycle2_write", {7'd0, WRITE}, 8'd1);
    chk("w1_addr", {5'd0, ADDR}, 8'd0);
    chk("w1_wdata", {6'd0, WRITE_DATA}, 8'd2);
    @(negedge CLK); chk("w1_cycle3_write", {7'd0, WRITE}, 8'd0);
    chk("w1_no_read", {7'd0, READ}, 8'd0);
    chk("w1_no_rsp", {7'd0, RSP_VALID}, 8'd0);
    chk("w1_single_pulse", 8'(wr_seen), 8'd1);
    @(posedge CLK); #1;

    // Write then read back at RD_LAT=1.
    send(1'b1, 3'd0, 2'b11);
    send(1'b0, 3'd0, 2'b00);
    drain();
    chk("rd1_count", 8'(rd_seen), 8'd1);

    // Back-to-back writes: one WRITE every two cycles.
    base_wr = wr_seen;
    for (int a = 0; a < 8; a++) send(1'b1, 3'(a), 2'(a + 1));
    drain();
    chk("b2b_writes", 8'(wr_seen - base_wr), 8'd8);
    for (int a = 7; a >= 0; a--) send(1'b0, 3'(a), 2'd0);
    drain();

    // Fill while the response is held off: five accepted, the sixth stalls.
    RSP_READY = 1'b0;
    send(1'b0, 3'd1, 2'd0);
    send(1'b1, 3'd2, 2'd3);
    send(1'b1, 3'd3, 2'd2);
    send(1'b1, 3'd4, 2'd1);
    send(1'b1, 3'd5, 2'd0);
    CMD_VALID = 1'b1; CMD_WR = 1'b1; CMD_ADDR = 3'd6; CMD_DATA = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("full_stall_ready", {7'd0, CMD_READY}, 8'd0);
    end
    chk("full_stall_rsp_valid", {7'd0, RSP_VALID}, 8'd1);
    @(posedge CLK); #1 RSP_READY = 1'b1;
    send(1'b1, 3'd6, 2'd1);
    drain();

    // Reset while waiting for read data.
    send(1'b1, 3'd7, 2'b01);
    drain();
    RSP_READY = 1'b0;
    send(1'b0, 3'd5, 2'b11);
    n = 0;
    while (!READ && n < 20) begin @(negedge CLK); n++; end
    chk("rdwait_read_seen", {7'd0, READ}, 8'd1);
    @(posedge CLK); #2 RST_N = 1'b0;
    #1 chk_reset_outputs("rst_rdwait");
    rq.delete();
    @(posedge CLK); #1 RST_N = 1'b1;
    base_rd = rd_seen;
    RSP_READY = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("rst_rdwait_no_rsp", {7'd0, RSP_VALID}, 8'd0);
    end
    chk("rst_rdwait_no_read", 8'(rd_seen - base_rd), 8'd0);
    @(posedge CLK); #1;

    // Reset while a response is being held.
    RSP_READY = 1'b0;
    send(1'b0, 3'd6, 2'b10);
    n = 0;
    while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
    chk("resp_valid_seen", {7'd0, RSP_VALID}, 8'd1);
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs("rst_resp");
    rq.delete();
    @(posedge CLK); #1 RST_N = 1'b1;
    RSP_READY = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("rst_resp_no_rsp", {7'd0, RSP_VALID}, 8'd0);
    end
    @(posedge CLK); #1;

    // RD_LAT=3 instance: data sampled three cycles after READ.
    c3_valid = 1'b1; c3_wr = 1'b0; c3_addr = 3'd3;
    @(posedge CLK); #1 c3_valid = 1'b0;
    n = 0;
    while (!c3_read && n < 20) begin @(negedge CLK); n++; end
    chk("lat3_read_seen", {7'd0, c3_read}, 8'd1);
    exp3 = rd3_cnt + 2'd3;
    k = 0;
    while (!c3_rsp_valid && k < 20) begin @(negedge CLK); k++; end
    chk("lat3_rsp_latency", 8'(k), 8'd4);
    chk("lat3_rsp_data", {6'd0, c3_rsp_data}, {6'd0, exp3});
    chk("lat3_rsp_addr", {5'd0, c3_rsp_addr}, 8'd3);
    @(posedge CLK); #1;

    // Random mixed traffic with a wobbling response ready.
    rnd_mode = 1'b1;
    repeat (1000) begin
      rwr  = 1'($urandom_range(0, 1));
      ra   = 3'($urandom_range(0, 7));
      rdat = 2'($urandom_range(0, 3));
      send(rwr, ra, rdat);
      if ($urandom_range(0, 3) == 0) begin @(posedge CLK); #1; end
    end
    rnd_mode = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_access_seq.md
REG_ACCESS_SEQ -- requirements
Module: reg_access_seq

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from READ strobe to valid READ_DATA (1..4).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CMD_VALID  input  1  host command valid.
REQ-006 SHALL have port CMD_READY  output  1  FIFO can accept command.
REQ-007 SHALL have port CMD_WR  input  1  1 = write, 0 = read.
REQ-008 SHALL have port CMD_ADDR  input  3  target register address.
REQ-009 SHALL have port CMD_DATA  input  2  write data; ignored for reads.
REQ-010 SHALL have port WRITE  output  1  one-cycle write strobe to register block.
REQ-011 SHALL have port READ  output  1  one-cycle read strobe to register block.
REQ-012 SHALL have port ADDR  output  3  register address, held stable through access.
REQ-013 SHALL have port WRITE_DATA  output  2  write data, valid with WRITE.
REQ-014 SHALL have port READ_DATA  input  2  read data from register block.
REQ-015 SHALL have port RSP_VALID  output  1  read response valid.
REQ-016 SHALL have port RSP_READY  input  1  host accepts response.
REQ-017 SHALL have port RSP_ADDR  output  3  address of the read being returned.
REQ-018 SHALL have port RSP_DATA  output  2  captured read data.

Function
REQ-019 Command accepted on a cycle with CMD_VALID && CMD_READY; CMD_READY = FIFO not full, independent of CMD_VALID.
REQ-020 FIFO SHALL accept push and pop in the same cycle when full (pop first frees slot, CMD_READY stays 1 only if not full before the edge; no bypass).
REQ-021 FSM states: IDLE, ISSUE, RD_WAIT, RESP.
REQ-022 IDLE -> ISSUE when FIFO non-empty; the head entry is popped on that transition and latched into ADDR/WRITE_DATA/op.
REQ-023 ISSUE lasts exactly one cycle: asserts WRITE (write op) or READ (read op), never both; write -> IDLE, read -> RD_WAIT.
REQ-024 RD_WAIT counts RD_LAT-1 further cycles, then captures READ_DATA on the cycle exactly RD_LAT after READ into RSP_DATA and -> RESP.
REQ-025 RESP holds RSP_VALID=1 with RSP_ADDR/RSP_DATA stable until RSP_READY=1, then -> IDLE.
REQ-026 Back-to-back writes SHALL issue one WRITE every 2 cycles (IDLE, ISSUE); commands execute strictly in FIFO order.
REQ-027 ADDR SHALL hold its last value between accesses; WRITE_DATA held likewise.
REQ-028 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; full = MSBs differ, lower bits equal.

Reset
REQ-029 On RST_N=0 (asynchronous, any state, including mid-read or RESP) SHALL go to IDLE, empty FIFO, discard pending response.
REQ-030 Reset values: CMD_READY=1 (after reset asserted), WRITE=0, READ=0, ADDR=0, WRITE_DATA=0, RSP_VALID=0, RSP_ADDR=0, RSP_DATA=0.
REQ-031 Release of RST_N SHALL not generate any strobe in the first cycle.

Structure
REQ-032 Shared package reg_access_pkg SHALL hold the FSM state enum (logic [1:0]) and command struct {wr, addr[2:0], data[1:0]}.
REQ-033 One sub-module, reg_access_fifo (parameterized sync FIFO of the command struct), SHALL be instantiated; FSM stays in reg_access_seq.

Verification
REQ-034 Write ADDR=0 DATA=2'b10 -> exactly one WRITE pulse with ADDR=0, WRITE_DATA=2'b10, 2 cycles after acceptance; no READ, no RSP_VALID.
REQ-035 Write ADDR=0 DATA=2'b11 then read ADDR=0, RD_LAT=1 -> RSP_VALID with RSP_ADDR=0, RSP_DATA=2'b11.
REQ-036 Push 5 commands with RSP_READY=0, first a read -> CMD_READY drops after 4th accepted... FSM pops 1, so 5 accepted, 6th stalls with CMD_READY=0 until RSP_READY=1.
REQ-037 RD_LAT=3, read with READ_DATA changing each cycle -> RSP_DATA equals value present 3 cycles after READ.
REQ-038 Assert RST_N=0 during RD_WAIT and during RESP -> all outputs at reset values immediately; no response after release.
REQ-039 Random 1000 mixed commands vs. scoreboard model of 8x2-bit register file -> every RSP_DATA matches, order preserved.
